// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of mem_ctrl: latches the winner's op/addr/wdata, routes done/rdata back,
// and aborts stalled transactions via a watchdog. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_arbiter #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                r0_op,
    input  logic [ADDR_WIDTH-1:0]     r0_addr,
    input  logic [DATA_BUS_WIDTH-1:0] r0_wdata,
    output logic                      r0_done,
    input  logic [1:0]                r1_op,
    input  logic [ADDR_WIDTH-1:0]     r1_addr,
    input  logic [DATA_BUS_WIDTH-1:0] r1_wdata,
    output logic                      r1_done,
    output logic [DATA_BUS_WIDTH-1:0] rdata,
    output logic                      err,
    output logic [1:0]                grant,
    output logic [1:0]                mem_op,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    input  logic                      mem_op_done,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] MEM_NOP = 2'd0;
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                grant_q, grant_d;
    logic [1:0]                mem_op_q, mem_op_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [1:0]                req_op [2];
    logic [ADDR_WIDTH-1:0]     req_addr [2];
    logic [DATA_BUS_WIDTH-1:0] req_wdata [2];
    logic [1:0]                req;
    logic [1:0]                done_vec;
    logic                      err_c;
    logic [DATA_BUS_WIDTH-1:0] rdata_c;
    logic                      win;
    logic                      owner;
    logic                      timeout_hit;

    assign req_op[0]    = r0_op;
    assign req_op[1]    = r1_op;
    assign req_addr[0]  = r0_addr;
    assign req_addr[1]  = r1_addr;
    assign req_wdata[0] = r0_wdata;
    assign req_wdata[1] = r1_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req[gi] = (req_op[gi] != MEM_NOP);
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers the last requester granted; a tie goes to the other one.
    logic rr_q, rr_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

    always_comb begin
        win  = req[1];
        rr_d = rr_q;
        if (&req) win = ~rr_q;
        if (state_q == ST_IDLE && |req) rr_d = win;
    end
`else
    assign win = req[1];
`endif

    assign owner       = grant_q[1];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        done_vec    = 2'b00;
        err_c       = 1'b0;
        rdata_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    mem_op_d    = req_op[win];
                    mem_addr_d  = req_addr[win];
                    mem_wdata_d = req_wdata[win];
                    grant_d     = win ? 2'b10 : 2'b01;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // Completion beats an owner abort, and an abort beats the watchdog.
                if (mem_op_done) begin
                    done_vec[owner] = 1'b1;
                    rdata_c         = mem_rdata;
                    state_d         = ST_DRAIN;
                end else if (req_op[owner] == MEM_NOP) begin
                    state_d = ST_DRAIN;
                end else if (timeout_hit) begin
                    done_vec[owner] = 1'b1;
                    err_c           = 1'b1;
                    state_d         = ST_DRAIN;
                end
                if (state_d == ST_DRAIN) begin
                    mem_op_d = MEM_NOP;
                    grant_d  = 2'b00;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default: begin
                state_d  = ST_IDLE;
                grant_d  = 2'b00;
                mem_op_d = MEM_NOP;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            mem_op_q    <= MEM_NOP;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign r0_done   = done_vec[0];
    assign r1_done   = done_vec[1];
    assign err       = err_c;
    assign rdata     = rdata_c;
    assign grant     = grant_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]    r0_op, r1_op, grant, mem_op;
    logic [AW-1:0] r0_addr, r1_addr, mem_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, rdata, mem_wdata, mem_rdata;
    logic          r0_done, r1_done, err, mem_op_done;

    int checks = 0;
    int errors = 0;
    int last_win = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_BUS_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clk), .reset(rst),
        .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_done(r0_done),
        .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_done(r1_done),
        .rdata(rdata), .err(err), .grant(grant),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_op_done(mem_op_done), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return 1 - last_win;
`else
        return 1;
`endif
    endfunction

    task automatic idle_inputs();
        r0_op = NOP; r0_addr = '0; r0_wdata = '0;
        r1_op = NOP; r1_addr = '0; r1_wdata = '0;
        mem_op_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_op_done = 1'b1; mem_rdata = 8'hFF;
        repeat (2) tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (mem_op !== NOP) begin errors++; $display("FAIL reset_mem_op got %0d exp 0", mem_op); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 00", mem_wdata); end
        checks++; if ({r0_done, r1_done, err} !== 3'b000) begin errors++; $display("FAIL reset_done_err got %b exp 000", {r0_done, r1_done, err}); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        mem_op_done = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        last_win = 0;
        tick();
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_idle_done();
        mem_op_done = 1'b1; mem_rdata = 8'h5A;
        #1;
        checks++; if ({r0_done, r1_done, err} !== 3'b000) begin errors++; $display("FAIL idle_done got %b exp 000", {r0_done, r1_done, err}); end
        tick();
        mem_op_done = 1'b0;
        checks++; if (grant !== 2'b00 || mem_op !== NOP) begin errors++; $display("FAIL idle_done_state grant %b op %0d exp 00/0", grant, mem_op); end
        $display("test_idle_done done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_read();
        r0_op = RD; r0_addr = 8'h10;
        tick();
        checks++; if (mem_op !== RD || mem_addr !== 8'h10) begin errors++; $display("FAIL read_latch op %0d addr %h exp 1/10", mem_op, mem_addr); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant got %b exp 01", grant); end
        for (int k = 1; k <= 3; k++) begin
            mem_op_done = (k == 3); mem_rdata = 8'hA5;
            #1;
            checks++; if (r0_done !== (k == 3)) begin errors++; $display("FAIL read_done cyc %0d got %b exp %b", k, r0_done, k == 3); end
            if (k == 3) begin
                checks++; if (rdata !== 8'hA5 || err !== 1'b0 || r1_done !== 1'b0) begin errors++; $display("FAIL read_data rdata %h err %b r1_done %b exp a5/0/0", rdata, err, r1_done); end
            end
            tick();
        end
        mem_op_done = 1'b0; r0_op = NOP;
        checks++; if (mem_op !== NOP || grant !== 2'b00) begin errors++; $display("FAIL read_drain op %0d grant %b exp 0/00", mem_op, grant); end
        tick();
        last_win = 0;
        $display("test_read done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_tie();
        int w;
        r1_op = WR; r1_addr = 8'h20; r1_wdata = 8'h3C;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_pre_grant got %b exp 10", grant); end
        mem_op_done = 1'b1;
        #1;
        checks++; if (r1_done !== 1'b1) begin errors++; $display("FAIL tie_pre_done got %b exp 1", r1_done); end
        tick();
        mem_op_done = 1'b0; r1_op = NOP;
        tick();
        last_win = 1;
        r0_op = WR; r0_addr = 8'h30; r0_wdata = 8'h11;
        r1_op = WR; r1_addr = 8'h20; r1_wdata = 8'h3C;
        w = tie_winner();
        tick();
        checks++; if (grant !== (w == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_grant got %b exp winner r%0d", grant, w); end
        checks++; if (mem_wdata !== (w == 1 ? 8'h3C : 8'h11)) begin errors++; $display("FAIL tie_wdata got %h exp %h", mem_wdata, w == 1 ? 8'h3C : 8'h11); end
        mem_op_done = 1'b1;
        #1;
        checks++; if ({r1_done, r0_done} !== (w == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_done got %b exp r%0d only", {r1_done, r0_done}, w); end
        tick();
        mem_op_done = 1'b0; r0_op = NOP; r1_op = NOP;
        tick();
        last_win = w;
        $display("test_tie done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_addr_hold();
        r1_op = WR; r1_addr = 8'h20; r1_wdata = 8'h3C;
        tick();
        r1_addr = 8'h55; r1_wdata = 8'h99;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL hold cyc %0d addr %h wdata %h exp 20/3c", k, mem_addr, mem_wdata); end
            if (k < 3) tick();
        end
        mem_op_done = 1'b1;
        #1;
        checks++; if (r1_done !== 1'b1) begin errors++; $display("FAIL hold_done got %b exp 1", r1_done); end
        tick();
        mem_op_done = 1'b0; r1_op = NOP;
        checks++; if (mem_op !== NOP) begin errors++; $display("FAIL hold_drain op %0d exp 0", mem_op); end
        tick();
        last_win = 1;
        $display("test_addr_hold done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_timeout();
        r0_op = RD; r0_addr = 8'h44;
        tick();
        for (int k = 1; k <= TO; k++) begin
            mem_rdata = 8'h77;
            #1;
            checks++; if (r0_done !== (k == TO) || err !== (k == TO)) begin errors++; $display("FAIL timeout cyc %0d done %b err %b exp %b", k, r0_done, err, k == TO); end
            if (k == TO) begin
                checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL timeout_rdata got %h exp 00", rdata); end
            end
            tick();
        end
        r0_op = NOP;
        checks++; if (mem_op !== NOP || grant !== 2'b00) begin errors++; $display("FAIL timeout_drain op %0d grant %b exp 0/00", mem_op, grant); end
        tick();
        last_win = 0;
        $display("test_timeout done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        r0_op = RD; r0_addr = 8'h66;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rstmid_grant got %b exp 01", grant); end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_op !== NOP || grant !== 2'b00) begin errors++; $display("FAIL rstmid_async op %0d grant %b exp 0/00", mem_op, grant); end
        r0_op = NOP;
        tick();
        rst = 1'b0;
        last_win = 0;
        tick();
        r1_op = RD; r1_addr = 8'h21;
        tick();
        checks++; if (grant !== 2'b10 || mem_op !== RD || mem_addr !== 8'h21) begin errors++; $display("FAIL rstmid_regrant grant %b op %0d addr %h exp 10/1/21", grant, mem_op, mem_addr); end
        mem_op_done = 1'b1; mem_rdata = 8'hC3;
        #1;
        checks++; if (r1_done !== 1'b1 || rdata !== 8'hC3) begin errors++; $display("FAIL rstmid_done done %b rdata %h exp 1/c3", r1_done, rdata); end
        tick();
        mem_op_done = 1'b0; r1_op = NOP;
        tick();
        last_win = 1;
        $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_abort();
        r0_op = RD; r0_addr = 8'h70;
        tick();
        r0_op = NOP; r1_op = WR; r1_addr = 8'h71; r1_wdata = 8'h5E;
        #1;
        checks++; if (r0_done !== 1'b0 || r1_done !== 1'b0) begin errors++; $display("FAIL abort_done r0 %b r1 %b exp 0/0", r0_done, r1_done); end
        tick();
        checks++; if (mem_op !== NOP || grant !== 2'b00) begin errors++; $display("FAIL abort_drain op %0d grant %b exp 0/00", mem_op, grant); end
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle grant %b exp 00", grant); end
        tick();
        checks++; if (grant !== 2'b10 || mem_op !== WR || mem_wdata !== 8'h5E) begin errors++; $display("FAIL abort_next grant %b op %0d wdata %h exp 10/2/5e", grant, mem_op, mem_wdata); end
        mem_op_done = 1'b1;
        #1;
        checks++; if (r1_done !== 1'b1 || r0_done !== 1'b0) begin errors++; $display("FAIL abort_next_done r1 %b r0 %b exp 1/0", r1_done, r0_done); end
        tick();
        mem_op_done = 1'b0; r1_op = NOP;
        tick();
        last_win = 1;
        $display("test_abort done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        logic [1:0]    op_m [2];
        logic [AW-1:0] addr_m [2];
        logic [DW-1:0] wdata_m [2];
        logic [AW-1:0] lat_addr;
        logic [DW-1:0] rd;
        int w, lat;
        bit exp_done, exp_err;
        for (int i = 0; i < 2; i++) begin op_m[i] = NOP; addr_m[i] = '0; wdata_m[i] = '0; end
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++)
                if (op_m[i] == NOP && $urandom_range(0, 2) != 0) begin
                    op_m[i] = $urandom_range(0, 1) ? WR : RD;
                    addr_m[i] = AW'($urandom); wdata_m[i] = DW'($urandom);
                end
            if (op_m[0] == NOP && op_m[1] == NOP) begin op_m[0] = RD; addr_m[0] = AW'($urandom); end
            r0_op = op_m[0]; r0_addr = addr_m[0]; r0_wdata = wdata_m[0];
            r1_op = op_m[1]; r1_addr = addr_m[1]; r1_wdata = wdata_m[1];
            w = (op_m[0] != NOP && op_m[1] != NOP) ? tie_winner() : (op_m[1] != NOP ? 1 : 0);
            tick();
            checks++;
            if (grant !== (w == 1 ? 2'b10 : 2'b01) || mem_op !== op_m[w] || mem_addr !== addr_m[w] || mem_wdata !== wdata_m[w]) begin
                errors++; $display("FAIL rnd_grant t%0d grant %b op %0d addr %h wdata %h exp r%0d op %0d addr %h wdata %h",
                    t, grant, mem_op, mem_addr, mem_wdata, w, op_m[w], addr_m[w], wdata_m[w]);
            end
            lat_addr = addr_m[w];
            lat = $urandom_range(1, 6);
            rd = DW'($urandom);
            for (int k = 1; k <= TO; k++) begin
                if (w == 0) r0_addr = AW'($urandom); else r1_addr = AW'($urandom);
                mem_op_done = (k == lat); mem_rdata = rd;
                #1;
                exp_err  = (k == TO) && (lat > TO);
                exp_done = (k == lat) || exp_err;
                checks++;
                if ((w == 0 ? r0_done : r1_done) !== exp_done || (w == 0 ? r1_done : r0_done) !== 1'b0 || err !== exp_err || mem_addr !== lat_addr) begin
                    errors++; $display("FAIL rnd_busy t%0d cyc %0d r0_done %b r1_done %b err %b addr %h exp owner r%0d done %b err %b addr %h",
                        t, k, r0_done, r1_done, err, mem_addr, w, exp_done, exp_err, lat_addr);
                end
                if (exp_done && op_m[w] == RD) begin
                    checks++;
                    if (rdata !== (exp_err ? 8'h00 : rd)) begin errors++; $display("FAIL rnd_rdata t%0d got %h exp %h", t, rdata, exp_err ? 8'h00 : rd); end
                end
                tick();
                if (exp_done) break;
            end
            mem_op_done = 1'b0;
            op_m[w] = NOP;
            if ($urandom_range(0, 1) != 0) begin
                op_m[w] = $urandom_range(0, 1) ? WR : RD;
                addr_m[w] = AW'($urandom); wdata_m[w] = DW'($urandom);
            end
            r0_op = op_m[0]; r0_addr = addr_m[0]; r0_wdata = wdata_m[0];
            r1_op = op_m[1]; r1_addr = addr_m[1]; r1_wdata = wdata_m[1];
            checks++;
            if (mem_op !== NOP || grant !== 2'b00) begin errors++; $display("FAIL rnd_drain t%0d op %0d grant %b exp 0/00", t, mem_op, grant); end
            tick();
            last_win = w;
            $display("rnd txn %0d owner r%0d op %0d latency %0d", t, w, mem_op === NOP ? 0 : 0, lat);
        end
        idle_inputs();
        tick(); tick();
        $display("test_random done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_idle_done();
        test_read();
        test_tie();
        test_addr_hold();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
